// File: rtl/alu_z_stage.sv
// Result-capture FIFO behind the ALU: buffers {ZHigh,ZLow} with valid/ready on both sides.
// Define ALU_Z_FLAGS_EN to store per-entry {N,Z} flags; otherwise z_flags reads 2'b00.
module alu_z_stage #(
    parameter int              DATA_W = 32,
    parameter int              DEPTH  = 2,
    parameter int              OP_W   = 5,
    parameter logic [OP_W-1:0] OP_MUL = OP_W'(5'h0F),
    parameter logic [OP_W-1:0] OP_DIV = OP_W'(5'h10)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_lo,
    input  logic [DATA_W-1:0] in_hi,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] z_lo,
    output logic [DATA_W-1:0] z_hi,
    output logic [1:0]        z_flags
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshake: a beat transfers on the rising edge where valid && ready are both high;
    // ready never depends on valid of the same side, and there is no bypass when full.
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_t;

    occ_t              occ, occ_next;
    logic [CNT_W-1:0]  count, count_next;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [DATA_W-1:0] lo_mem [DEPTH];
    logic [DATA_W-1:0] hi_mem [DEPTH];
    logic              push, pop;

    assign in_ready  = (occ != OCC_FULL);
    assign out_valid = (occ != OCC_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign z_lo      = lo_mem[rd_ptr];
    assign z_hi      = hi_mem[rd_ptr];

    always_comb begin
        count_next = count;
        occ_next   = occ;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
        if (count_next == '0)
            occ_next = OCC_EMPTY;
        else if (count_next == CNT_W'(DEPTH))
            occ_next = OCC_FULL;
        else
            occ_next = OCC_PARTIAL;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            occ    <= OCC_EMPTY;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                lo_mem[i] <= '0;
                hi_mem[i] <= '0;
            end
        end else begin
            occ   <= occ_next;
            count <= count_next;
            if (push) begin
                lo_mem[wr_ptr] <= in_lo;
                hi_mem[wr_ptr] <= in_hi;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

`ifdef ALU_Z_FLAGS_EN
    logic [1:0] flag_mem [DEPTH];

    // Divide flags look at the quotient only; multiply flags see the whole 64-bit product.
    function automatic logic [1:0] flags_of(input logic [OP_W-1:0] op,
                                            input logic [DATA_W-1:0] hi,
                                            input logic [DATA_W-1:0] lo);
        if (op == OP_MUL)
            return {hi[DATA_W-1], ({hi, lo} == '0)};
        else if (op == OP_DIV)
            return {lo[DATA_W-1], (lo == '0)};
        else
            return {lo[DATA_W-1], (lo == '0)};
    endfunction

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++)
                flag_mem[i] <= 2'b00;
        end else if (push) begin
            flag_mem[wr_ptr] <= flags_of(in_op, in_hi, in_lo);
        end
    end

    assign z_flags = flag_mem[rd_ptr];
`else
    logic [OP_W-1:0] unused_op;

    assign unused_op = in_op ^ OP_MUL ^ OP_DIV;
    assign z_flags   = 2'b00;
`endif

endmodule

// File: tb/tb_alu_z_stage.sv
// Directed bench for alu_z_stage (DEPTH=2): vector table plus hand sequences for
// push&pop wrap, full-stall and clear-while-busy.
module tb_alu_z_stage;
    logic        clk;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [31:0] in_lo;
    logic [31:0] in_hi;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z_lo;
    logic [31:0] z_hi;
    logic [1:0]  z_flags;

    int passed = 0;
    int total  = 0;

    alu_z_stage dut (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_lo     (in_lo),
        .in_hi     (in_hi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z_lo      (z_lo),
        .z_hi      (z_hi),
        .z_flags   (z_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        in_valid;
        logic [4:0]  op;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        out_ready;
        logic        exp_ov;
        logic        exp_ir;
        logic [1:0]  exp_cnt;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        logic [1:0]  exp_flags;
    } vec_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [1:0]  flags;
    } item_t;

    vec_t        vecs[10];
    item_t       items[7];
    logic [65:0] exp_q[$];

    function automatic logic [1:0] fmask(input logic [1:0] f);
`ifdef ALU_Z_FLAGS_EN
        return f;
`else
        return 2'b00;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] hi,
                         input logic [31:0] lo, input logic rdy);
        in_valid  = v;
        in_op     = op;
        in_hi     = hi;
        in_lo     = lo;
        out_ready = rdy;
    endtask

    task automatic chk_head(input string tag);
        logic [65:0] e;
        e = exp_q[0];
        chk({tag, "_ov"}, 64'(out_valid), 64'd1);
        chk({tag, "_lo"}, 64'(z_lo), 64'(e[31:0]));
        chk({tag, "_hi"}, 64'(z_hi), 64'(e[63:32]));
        chk({tag, "_flags"}, 64'(z_flags), 64'(fmask(e[65:64])));
    endtask

    initial begin
        // in_valid, op, lo, hi, out_ready, ov, ir, cnt, z_lo, z_hi, flags
        vecs[0] = '{1'b1, 5'h07, 32'h8000_0001, 32'h0, 1'b1, 1'b1, 1'b1, 2'd1, 32'h8000_0001, 32'h0, 2'b10};
        vecs[1] = '{1'b0, 5'h00, 32'h0,         32'h0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0,         32'h0, 2'b00};
        vecs[2] = '{1'b1, 5'h01, 32'h11,        32'h0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h11,        32'h0, 2'b00};
        vecs[3] = '{1'b1, 5'h01, 32'h22,        32'h0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h11,        32'h0, 2'b00};
        vecs[4] = '{1'b1, 5'h01, 32'h33,        32'h0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h11,        32'h0, 2'b00};
        vecs[5] = '{1'b1, 5'h01, 32'h44,        32'h0, 1'b1, 1'b1, 1'b1, 2'd1, 32'h22,        32'h0, 2'b00};
        vecs[6] = '{1'b0, 5'h00, 32'h0,         32'h0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0,         32'h0, 2'b00};
        vecs[7] = '{1'b0, 5'h00, 32'h0,         32'h0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0,         32'h0, 2'b00};
        vecs[8] = '{1'b1, 5'h03, 32'h0,         32'h0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h0,         32'h0, 2'b01};
        vecs[9] = '{1'b0, 5'h00, 32'h0,         32'h0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0,         32'h0, 2'b00};

        // op, hi, lo, expected {N,Z}
        items[0] = '{5'h0F, 32'h1,         32'h0,         2'b00};
        items[1] = '{5'h0F, 32'h0,         32'h0,         2'b01};
        items[2] = '{5'h10, 32'h5,         32'h8000_0000, 2'b10};
        items[3] = '{5'h10, 32'h7,         32'h0,         2'b01};
        items[4] = '{5'h0F, 32'h8000_0000, 32'h0,         2'b10};
        items[5] = '{5'h01, 32'h0,         32'h7FFF_FFFF, 2'b00};
        items[6] = '{5'h05, 32'h0,         32'hFFFF_FFFF, 2'b10};

        // Reset held two cycles, then released.
        clr = 1'b1;
        drive(1'b0, 5'h0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        clr = 1'b0;
        tick();
        chk("rst_ir", 64'(in_ready), 64'd1);
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_lo", 64'(z_lo), 64'd0);
        chk("rst_hi", 64'(z_hi), 64'd0);
        chk("rst_flags", 64'(z_flags), 64'd0);
        chk("rst_cnt", 64'(dut.count), 64'd0);

        // Table: latency, full stall, ignored push when full, pop-only when full, stray pop.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].in_valid, vecs[i].op, vecs[i].hi, vecs[i].lo, vecs[i].out_ready);
            tick();
            chk($sformatf("vec%0d_ov", i), 64'(out_valid), 64'(vecs[i].exp_ov));
            chk($sformatf("vec%0d_ir", i), 64'(in_ready), 64'(vecs[i].exp_ir));
            chk($sformatf("vec%0d_cnt", i), 64'(dut.count), 64'(vecs[i].exp_cnt));
            if (vecs[i].exp_ov) begin
                chk($sformatf("vec%0d_lo", i), 64'(z_lo), 64'(vecs[i].exp_lo));
                chk($sformatf("vec%0d_hi", i), 64'(z_hi), 64'(vecs[i].exp_hi));
                chk($sformatf("vec%0d_flags", i), 64'(z_flags), 64'(fmask(vecs[i].exp_flags)));
            end
        end

        // Stall hold: data must not move while out_ready=0.
        drive(1'b1, 5'h01, 32'h0, 32'hABCD_0123, 1'b0);
        exp_q.push_back({2'b00, 32'h0, 32'hABCD_0123});
        tick();
        drive(1'b0, 5'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_head($sformatf("hold%0d", i));
        end
        drive(1'b0, 5'h0, 32'h0, 32'h0, 1'b1);
        tick();
        void'(exp_q.pop_front());
        chk("hold_drain_ov", 64'(out_valid), 64'd0);

        // PARTIAL: one entry held, then six back-to-back push&pop cycles.
        drive(1'b1, items[0].op, items[0].hi, items[0].lo, 1'b0);
        exp_q.push_back({items[0].flags, items[0].hi, items[0].lo});
        tick();
        chk_head("pp_first");
        for (int i = 1; i < 7; i++) begin
            drive(1'b1, items[i].op, items[i].hi, items[i].lo, 1'b1);
            exp_q.push_back({items[i].flags, items[i].hi, items[i].lo});
            tick();
            void'(exp_q.pop_front());
            chk_head($sformatf("pp%0d", i));
            chk($sformatf("pp%0d_cnt", i), 64'(dut.count), 64'd1);
        end
        drive(1'b0, 5'h0, 32'h0, 32'h0, 1'b1);
        tick();
        void'(exp_q.pop_front());
        chk("pp_drain_ov", 64'(out_valid), 64'd0);
        chk("pp_drain_cnt", 64'(dut.count), 64'd0);

        // Clear while full with a push pending.
        drive(1'b1, 5'h01, 32'h0, 32'h66, 1'b0);
        tick();
        drive(1'b1, 5'h01, 32'h0, 32'h77, 1'b0);
        tick();
        chk("clr_pre_cnt", 64'(dut.count), 64'd2);
        clr = 1'b1;
        drive(1'b1, 5'h01, 32'h0, 32'h88, 1'b1);
        tick();
        clr = 1'b0;
        drive(1'b0, 5'h0, 32'h0, 32'h0, 1'b0);
        chk("clr_cnt", 64'(dut.count), 64'd0);
        chk("clr_ov", 64'(out_valid), 64'd0);
        chk("clr_ir", 64'(in_ready), 64'd1);
        chk("clr_lo", 64'(z_lo), 64'd0);

        // Operation resumes after the clear.
        drive(1'b1, 5'h01, 32'h0, 32'h55, 1'b0);
        exp_q.push_back({2'b00, 32'h0, 32'h55});
        tick();
        chk_head("post_clr");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
